// File: rtl/mem_pkg.sv
// Shared types and constants for the external-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

endpackage

// File: rtl/mem_array.sv
// Word array with synchronous write and combinational read; contents are never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_BITS)-1];

  // Storage update on the write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: four-phase EN/MFC handshake around a word array,
// with a programmable access latency and out-of-range address detection.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              MFC,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e               r_state, w_state_nxt;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic                 r_rw, w_rw_nxt;
  logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]    r_dout, w_dout_nxt;
  logic                 r_mfc, w_mfc_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_we;
  logic                 w_addr_oor;
  logic [DATA_W-1:0]    w_rdata;

  assign w_addr_oor = (address >> ADDR_BITS) != {ADDR_W{1'b0}};

  mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .we   (w_we),
    .waddr(r_addr),
    .wdata(r_wdata),
    .raddr(r_addr),
    .rdata(w_rdata)
  );

  // Next-state, operand latching and output-register next values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_rw_nxt    = r_rw;
    w_wdata_nxt = r_wdata;
    w_dout_nxt  = r_dout;
    w_mfc_nxt   = r_mfc;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (EN) begin
          w_addr_nxt  = address[ADDR_BITS-1:0];
          w_rw_nxt    = RW;
          w_wdata_nxt = dataIn;
          w_cnt_nxt   = CNT_LOAD;
          w_err_nxt   = w_addr_oor;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!EN) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_busy_nxt  = 1'b0;
          w_mfc_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
          // An out-of-range access still completes the handshake but never touches the array.
          if (r_rw == RW_READ) begin
            w_dout_nxt = r_err ? 16'h0000 : w_rdata;
          end else begin
            w_we = ~r_err;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (!EN) begin
          w_mfc_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_mfc_nxt = 1'b1;
        end
      end
      default: begin
        w_mfc_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= {ADDR_BITS{1'b0}};
      r_rw    <= RW_WRITE;
      r_wdata <= 16'h0000;
      r_dout  <= 16'h0000;
      r_mfc   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_rw    <= w_rw_nxt;
      r_wdata <= w_wdata_nxt;
      r_dout  <= w_dout_nxt;
      r_mfc   <= w_mfc_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign dataOut = r_dout;
  assign MFC     = r_mfc;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: four responders (LATENCY 2,3,1,15) driven by directed and
// random handshakes, checked against an address->data reference map.
module tb_mem_responder;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       en = 4'd0;
  logic [3:0]       rw = 4'd0;
  logic [3:0][15:0] addr = '0;
  logic [3:0][15:0] din = '0;
  logic [3:0][15:0] dout;
  logic [3:0]       mfc;
  logic [3:0]       busy;
  logic [3:0]       err;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] mdl [int];
  logic [15:0] last_dout [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 15;
    mem_responder #(.ADDR_BITS(8), .LATENCY(L)) u_dut (
      .clk(clk), .rst(rst), .EN(en[g]), .RW(rw[g]), .address(addr[g]),
      .dataIn(din[g]), .dataOut(dout[g]), .MFC(mfc[g]), .busy(busy[g]), .err(err[g])
    );
  end

  function automatic int lat_of(input int k);
    case (k)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full four-phase access on instance k; scramble perturbs operands after acceptance.
  task automatic access(input int k, input logic r, input logic [15:0] a, input logic [15:0] d,
                        input bit scramble);
    logic        e_err;
    logic [15:0] e_dout;
    int          n;
    int          key;
    e_err = (a > 16'h00FF);
    key   = k * 65536 + int'(a);
    if (r) e_dout = e_err ? 16'h0000 : mdl[key];
    else   e_dout = last_dout[k];
    @(negedge clk);
    en[k] = 1'b1; rw[k] = r; addr[k] = a; din[k] = d;
    @(posedge clk); #1;
    chk("accept_busy", 32'(busy[k]), 32'd1);
    chk("accept_mfc", 32'(mfc[k]), 32'd0);
    chk("accept_err", 32'(err[k]), 32'(e_err));
    if (scramble) begin
      addr[k] = a + 16'd1; rw[k] = ~r; din[k] = 16'($urandom);
    end
    n = 0;
    while (mfc[k] !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("mfc_latency", 32'(n), 32'(lat_of(k)));
    chk("done_dout", 32'(dout[k]), 32'(e_dout));
    chk("done_err", 32'(err[k]), 32'(e_err));
    chk("done_busy", 32'(busy[k]), 32'd0);
    @(posedge clk); #1;
    chk("hold_mfc", 32'(mfc[k]), 32'd1);
    chk("hold_dout", 32'(dout[k]), 32'(e_dout));
    @(negedge clk);
    en[k] = 1'b0;
    @(posedge clk); #1;
    chk("release_mfc", 32'(mfc[k]), 32'd0);
    chk("release_dout", 32'(dout[k]), 32'(e_dout));
    chk("release_err", 32'(err[k]), 32'(e_err));
    last_dout[k] = e_dout;
    if (!r && !e_err) mdl[key] = d;
  endtask

  initial begin
    int          rises;
    logic        prev;
    logic        r;
    logic [15:0] a;
    int          k;

    for (int i = 0; i < 4; i++) last_dout[i] = 16'h0000;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_mfc", 32'(mfc[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
      chk("reset_dout", 32'(dout[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Write then read back
    access(0, 1'b0, 16'h0010, 16'hBEEF, 1'b0);
    access(0, 1'b1, 16'h0010, 16'h0000, 1'b0);

    // Out-of-range write must not alias onto word 0
    access(0, 1'b0, 16'h0000, 16'h0F0F, 1'b0);
    access(0, 1'b0, 16'h0100, 16'h1234, 1'b0);
    access(0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    access(0, 1'b1, 16'h0100, 16'h0000, 1'b0);

    // Abort on LATENCY=3 instance
    access(1, 1'b0, 16'h0005, 16'h1111, 1'b0);
    @(negedge clk);
    en[1] = 1'b1; rw[1] = 1'b0; addr[1] = 16'h0005; din[1] = 16'hAAAA;
    @(posedge clk); #1;
    chk("abort_busy_on", 32'(busy[1]), 32'd1);
    en[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_off", 32'(busy[1]), 32'd0);
    rises = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mfc[1] === 1'b1) rises++;
    end
    chk("abort_no_mfc", 32'(rises), 32'd0);
    access(1, 1'b1, 16'h0005, 16'h0000, 1'b0);

    // Operands latched at acceptance
    access(0, 1'b0, 16'h0020, 16'h2020, 1'b0);
    access(0, 1'b0, 16'h0021, 16'h2121, 1'b0);
    access(0, 1'b1, 16'h0020, 16'h0000, 1'b1);
    access(0, 1'b1, 16'h0021, 16'h0000, 1'b0);

    // Asynchronous reset during a write discards it
    access(1, 1'b0, 16'h0007, 16'h7777, 1'b0);
    access(1, 1'b1, 16'h0007, 16'h0000, 1'b0);
    @(negedge clk);
    en[1] = 1'b1; rw[1] = 1'b0; addr[1] = 16'h0007; din[1] = 16'h5555;
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(busy[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mfc", 32'(mfc[1]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_dout", 32'(dout[1]), 32'd0);
    en[1] = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) last_dout[i] = 16'h0000;
    access(1, 1'b1, 16'h0007, 16'h0000, 1'b0);

    // Latency extremes
    access(2, 1'b0, 16'h0033, 16'hC0DE, 1'b0);
    access(2, 1'b1, 16'h0033, 16'h0000, 1'b0);
    access(3, 1'b0, 16'h00FF, 16'h5A5A, 1'b0);
    access(3, 1'b1, 16'h00FF, 16'h0000, 1'b0);

    // EN held high: exactly one completion
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b1; addr[0] = 16'h0010;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (mfc[0] === 1'b1 && prev !== 1'b1) rises++;
      prev = mfc[0];
    end
    chk("held_en_rises", 32'(rises), 32'd1);
    chk("held_en_dout", 32'(dout[0]), 32'hBEEF);
    @(negedge clk); en[0] = 1'b0;
    @(posedge clk); #1;
    chk("held_en_release", 32'(mfc[0]), 32'd0);
    last_dout[0] = 16'hBEEF;

    // Random traffic on the short-latency instances
    for (int i = 0; i < 24; i++) begin
      k = (i % 2 == 0) ? 0 : 2;
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = 16'($urandom_range(256, 65535));
      else a = 16'h0040 + 16'($urandom_range(0, 15));
      if (r && a <= 16'h00FF && !mdl.exists(k * 65536 + int'(a))) r = 1'b0;
      access(k, r, a, 16'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the microcontroller's external memory handshake. It accepts EN/RW/address/busOut from the controller, performs a read or write on an internal word array after a programmable wait, and returns data plus MFC (memory function complete). MFC is held until the controller drops EN, giving a full four-phase handshake. It sits outside the top-level, wired to its address/RW/EN/busOut outputs and to its busIn/MFC inputs.

Parameters:
ADDR_BITS, 8, log2 of array depth (256 words); address[15:ADDR_BITS] must be zero.
LATENCY, 2, cycles from request acceptance to MFC assertion; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
EN  input  1  request strobe from controller
RW  input  1  1 = read, 0 = write
address  input  16  word address
dataIn  input  16  write data (controller busOut)
dataOut  output  16  read data (controller busIn)
MFC  output  1  memory function complete
busy  output  1  high in BUSY state
err  output  1  out-of-range address on the current/last access

Behaviour:
- Reset: state IDLE, MFC=0, busy=0, err=0, dataOut=16'h0000, wait counter=0. Array contents are not reset.
- Reset mid-operation: return to IDLE immediately. Any pending write is discarded.
- States: IDLE, BUSY, DONE. Encoding comes from the package.
- IDLE: on an edge with EN=1, latch address, RW, and dataIn. Load counter=LATENCY-1, go to BUSY, busy=1. Set err=1 if address[15:ADDR_BITS]!=0, else err=0.
- BUSY: decrement the counter each edge.
  - At the edge where counter==0 and EN=1, go to DONE and set MFC=1.
  - Read: at the same edge, dataOut <= array[latched addr], or 16'h0000 if err.
  - Write: at the same edge, array[latched addr] <= latched data, suppressed if err. dataOut keeps its previous value.
  - Result: MFC rises exactly LATENCY cycles after the accepting edge.
- Abort: EN=0 sampled in BUSY goes to IDLE, busy=0, no array write, MFC never rises. err holds.
- Changes to RW, address, or dataIn after acceptance are ignored.
- DONE: MFC=1 and dataOut stable while EN=1. On an edge with EN=0, set MFC=0 and go to IDLE. dataOut holds its last value.
- No new request is accepted until EN has been low in DONE. Minimum gap between acceptances is LATENCY+2 cycles.
- EN held high continuously yields one access only.
- Simultaneous EN=1 in IDLE and rst=1: reset wins.
- All outputs are registered; there is no combinational path from inputs to MFC or dataOut.

Decomposition:
- Package mem_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - RW_READ=1'b1, RW_WRITE=1'b0;
  - DATA_W=16 and ADDR_W=16.
- Sub-module mem_array: synchronous write (we, waddr, wdata) and combinational read (raddr -> rdata), depth 2**ADDR_BITS, no reset.
- mem_responder holds the FSM, latches, counter, and output registers.

Test Plan:
- Write then read, LATENCY=2:
  - EN=1, RW=0, address=16'h0010, dataIn=16'hBEEF -> MFC=1 two edges after acceptance; MFC drops one edge after EN=0.
  - Then RW=1, address=16'h0010 -> dataOut=16'hBEEF with MFC, err=0.
- Out of range:
  - Write 16'h1234 to address=16'h0100 (ADDR_BITS=8) -> err=1, MFC still asserts, array[0x00] unchanged.
  - Read 16'h0100 -> dataOut=16'h0000, err=1.
- Abort:
  - Write 16'hAAAA to 16'h0005 with EN dropped after 1 cycle (LATENCY=3) -> MFC never rises, busy falls.
  - Read 16'h0005 -> prior contents returned.
- Latched operands: start a read at 16'h0020, then change address to 16'h0021 and RW=0 during BUSY -> read of 0x20 is returned; no write occurs.
- Reset mid-access: assert rst asynchronously in BUSY during a write of 16'h5555 to 16'h0007 -> MFC=0, busy=0, dataOut=0 immediately; a later read of 0x07 does not return 16'h5555.
- Latency sweep and held EN:
  - LATENCY=1 and LATENCY=15 -> MFC edge count equals LATENCY.
  - EN held high for 40 cycles -> exactly one MFC rise.
